// File: rtl/fft_twiddle_gen.sv
// Streaming Q1.FRAC twiddle source for one radix-2 DIF FFT stage: quarter-wave
// cosine ROM, quadrant symmetry and a two-stage valid/ready pipeline.
module fft_twiddle_gen #(
    parameter int LOG2N    = 6,
    parameter int TW_WIDTH = 12,
    parameter int FRAC     = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(LOG2N):0]     stage,
    input  logic                       tw_ready,
    output logic                       tw_valid,
    output logic signed [TW_WIDTH-1:0] tw_re,
    output logic signed [TW_WIDTH-1:0] tw_im,
    output logic                       tw_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int N   = 1 << LOG2N;
    localparam int Q   = N / 4;
    localparam int JW  = LOG2N - 1;
    localparam int AW  = LOG2N - 2;
    localparam int AW1 = AW + 1;
    localparam int SW  = $clog2(LOG2N) + 1;
    localparam int CW  = FRAC + 1;

    localparam longint PI_Q30 = 64'sd3373259426;
    localparam longint ONE_Q  = 64'sd1 << 30;
    localparam longint HALF_Q = 64'sd1 << 29;

    localparam logic [JW-1:0] J_MAX     = '1;
    localparam logic [SW-1:0] STAGE_LIM = SW'(LOG2N);

    // Elaboration-time cosine: Q30 Taylor series, then round half away from zero.
    function automatic logic [CW-1:0] cos_entry(input int m);
        longint x, x2, term, acc, scaled, r;
        x    = (PI_Q30 * 2 * longint'(m)) / longint'(N);
        x2   = (x * x) >>> 30;
        term = ONE_Q;
        acc  = ONE_Q;
        for (int unsigned k = 1; k <= 12; k++) begin
            term = -(((term * x2) >>> 30) / (longint'(2 * k - 1) * longint'(2 * k)));
            acc  = acc + term;
        end
        scaled = acc * longint'(1 << FRAC);
        if (scaled >= 0) r = (scaled + HALF_Q) >>> 30;
        else             r = -((-scaled + HALF_Q) >>> 30);
        return CW'(r);
    endfunction

    logic [CW-1:0] rom [0:Q];
    for (genvar g = 0; g <= Q; g++) begin : g_rom
        assign rom[g] = cos_entry(g);
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [SW-1:0]              s_q, s_d;
    logic [JW-1:0]              j_q, j_d;
    logic                       v1_q, v1_d;
    logic [AW-1:0]              a1_q, a1_d;
    logic                       q1_q, q1_d;
    logic                       l1_q, l1_d;
    logic                       tw_valid_q, tw_valid_d;
    logic signed [TW_WIDTH-1:0] tw_re_q, tw_re_d;
    logic signed [TW_WIDTH-1:0] tw_im_q, tw_im_d;
    logic                       tw_last_q, tw_last_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic                       advance;
    logic                       issue;
    logic [JW-1:0]              e;
    logic [AW1-1:0]             comp;
    logic signed [TW_WIDTH-1:0] c_dir, c_cmp;

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        v1_d       = v1_q;
        a1_d       = a1_q;
        q1_d       = q1_q;
        l1_d       = l1_q;
        tw_valid_d = tw_valid_q;
        tw_re_d    = tw_re_q;
        tw_im_d    = tw_im_q;
        tw_last_d  = tw_last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        issue      = 1'b0;

        // Whole pipeline moves together; a stalled output freezes everything behind it.
        advance = !tw_valid_q || tw_ready;
        e       = (j_q & ({JW{1'b1}} >> s_q)) << s_q;
        comp    = AW1'(Q) - {1'b0, a1_q};
        c_dir   = TW_WIDTH'(rom[{1'b0, a1_q}]);
        c_cmp   = TW_WIDTH'(rom[comp]);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (stage < STAGE_LIM) begin
                        s_d     = stage;
                        j_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (advance) begin
                    issue = 1'b1;
                    j_d   = j_q + 1'b1;
                    if (j_q == J_MAX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tw_valid_q && tw_ready && tw_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            v1_d = issue;
            l1_d = issue && (j_q == J_MAX);
            if (issue) begin
                a1_d = e[AW-1:0];
                q1_d = e[AW];
            end
            tw_valid_d = v1_q;
            tw_last_d  = v1_q && l1_q;
            if (v1_q) begin
                if (!q1_q) begin
                    tw_re_d = c_dir;
                    tw_im_d = -c_cmp;
                end else begin
                    tw_re_d = -c_cmp;
                    tw_im_d = -c_dir;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            s_q        <= '0;
            j_q        <= '0;
            v1_q       <= 1'b0;
            a1_q       <= '0;
            q1_q       <= 1'b0;
            l1_q       <= 1'b0;
            tw_valid_q <= 1'b0;
            tw_re_q    <= '0;
            tw_im_q    <= '0;
            tw_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            v1_q       <= v1_d;
            a1_q       <= a1_d;
            q1_q       <= q1_d;
            l1_q       <= l1_d;
            tw_valid_q <= tw_valid_d;
            tw_re_q    <= tw_re_d;
            tw_im_q    <= tw_im_d;
            tw_last_q  <= tw_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tw_valid = tw_valid_q;
    assign tw_re    = tw_re_q;
    assign tw_im    = tw_im_q;
    assign tw_last  = tw_last_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Self-checking bench for fft_twiddle_gen: directed and randomized stages
// compared against a trigonometric reference model.
module tb_fft_twiddle_gen;
    localparam int LOG2N = 6;
    localparam int N     = 1 << LOG2N;
    localparam int NH    = N / 2;
    localparam real PI   = 3.14159265358979323846;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [3:0]        stage;
    logic              tw_ready;
    logic              tw_valid;
    logic signed [11:0] tw_re;
    logic signed [11:0] tw_im;
    logic              tw_last;
    logic              busy;
    logic              done;
    logic              err;

    int n_vec;
    int n_err;
    int cap_re [0:NH-1];
    int cap_im [0:NH-1];

    fft_twiddle_gen #(.LOG2N(LOG2N), .TW_WIDTH(12), .FRAC(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stage    (stage),
        .tw_ready (tw_ready),
        .tw_valid (tw_valid),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .tw_last  (tw_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int exp_of(input int s, input int j);
        return (j % (N >> (s + 1))) << s;
    endfunction

    function automatic int model_re(input int ex);
        return rnd(1024.0 * $cos(2.0 * PI * ex / N));
    endfunction

    function automatic int model_im(input int ex);
        return -rnd(1024.0 * $sin(2.0 * PI * ex / N));
    endfunction

    // Entered on a negedge; returns on the negedge where done should be visible.
    task automatic run_stage(input int s, input bit rnd_ready, input bit mid_start, input int abort_at);
        int c, hs, first_c, last_c, ex, pre, pim;
        logic pv, pr, pl;
        start = 1'b1;
        stage = 4'(s);
        tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", busy, 1);
        c = 0; hs = 0; first_c = -1; last_c = -1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pre = 0; pim = 0;
        while (hs < NH && c < 400) begin
            if (c < 2) chk("no_early_valid", tw_valid, 0);
            if (tw_valid && first_c < 0) begin
                first_c = c;
                chk("first_lat", c, 2);
            end
            if (pv && !pr) begin
                chk("stall_valid", tw_valid, 1);
                chk("stall_re", tw_re, pre);
                chk("stall_im", tw_im, pim);
                chk("stall_last", tw_last, pl);
            end
            if (hs == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_valid", tw_valid, 0);
                chk("abort_re", tw_re, 0);
                chk("abort_im", tw_im, 0);
                chk("abort_last", tw_last, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_err", err, 0);
                return;
            end
            if (mid_start && c == 5) begin
                start = 1'b1;
                stage = 4'((s + 3) % LOG2N);
            end else begin
                start = 1'b0;
            end
            if (mid_start && c == 6) chk("mid_no_err", err, 0);
            tw_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            if (tw_valid && tw_ready) begin
                ex = exp_of(s, hs);
                chk("re", tw_re, model_re(ex));
                chk("im", tw_im, model_im(ex));
                chk("last", tw_last, (hs == NH - 1) ? 1 : 0);
                cap_re[hs] = tw_re;
                cap_im[hs] = tw_im;
                hs++;
                last_c = c;
            end
            pv = tw_valid; pr = tw_ready; pl = tw_last; pre = tw_re; pim = tw_im;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("hs_count", hs, NH);
        if (!rnd_ready) chk("burst_len", last_c - first_c, NH - 1);
        chk("done_pulse", done, 1);
        chk("busy_off", busy, 0);
        chk("valid_off", tw_valid, 0);
        tw_ready = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stage = '0;
        tw_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", tw_valid, 0);
        chk("rst_re", tw_re, 0);
        chk("rst_im", tw_im, 0);
        chk("rst_last", tw_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_stage(0, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk("done_clr", done, 0);
        chk("s0_j0_re", cap_re[0], 1024);   chk("s0_j0_im", cap_im[0], 0);
        chk("s0_j8_re", cap_re[8], 724);    chk("s0_j8_im", cap_im[8], -724);
        chk("s0_j16_re", cap_re[16], 0);    chk("s0_j16_im", cap_im[16], -1024);
        chk("s0_j24_re", cap_re[24], -724); chk("s0_j24_im", cap_im[24], -724);
        chk("s0_j31_re", cap_re[31], -1019); chk("s0_j31_im", cap_im[31], -100);

        run_stage(1, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk("s1_j4_re", cap_re[4], 724);     chk("s1_j4_im", cap_im[4], -724);
        chk("s1_j16_re", cap_re[16], 1024);  chk("s1_j16_im", cap_im[16], 0);
        chk("s1_j31_re", cap_re[31], -1004); chk("s1_j31_im", cap_im[31], -200);

        run_stage(5, 1'b0, 1'b0, -1);
        @(negedge clk);
        run_stage(2, 1'b1, 1'b0, -1);
        @(negedge clk);

        // Back-to-back: second start is driven during the done cycle.
        run_stage(3, 1'b0, 1'b0, -1);
        run_stage(4, 1'b1, 1'b1, -1);
        @(negedge clk);
        chk("b2b_done_clr", done, 0);

        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            stage = 4'($urandom_range(15, LOG2N));
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_valid", tw_valid, 0);
            @(negedge clk);
            chk("err_clr", err, 0);
            chk("err_busy2", busy, 0);
            chk("err_valid2", tw_valid, 0);
        end

        run_stage(0, 1'b0, 1'b0, 10);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        tw_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", tw_valid, 0);
        run_stage(0, 1'b0, 1'b0, -1);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_stage(int'($urandom_range(LOG2N - 1, 0)), 1'b1, 1'b0, -1);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fft_twiddle_gen.md
Name: fft_twiddle_gen

Overview:
- Streaming twiddle-factor source for one radix-2 DIF FFT stage.
- Supplies the 12-bit Q1.10 twiddle operand (real and imaginary) to the team's complex multiplier. Its 1024 scale matches the multiplier's +512 round and >>10 renormalisation.
- Emits N/2 twiddles per started stage, in butterfly order, over a valid/ready stream.
- Uses a quarter-wave cosine ROM plus symmetry logic.

Parameters:
- LOG2N, 6, log2 of FFT size N (N=64 default); legal range 3..10.
- TW_WIDTH, 12, signed twiddle width.
- FRAC, 10, fractional bits; 1.0 = 2^FRAC = 1024.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to generate one stage; sampled only in IDLE
- stage  in  ceil(log2(LOG2N))+1  stage index s, sampled with start
- tw_ready  in  1  downstream accepts twiddle
- tw_valid  out  1  tw_re/tw_im valid
- tw_re  out  TW_WIDTH  signed real part, round(1024*cos(2πe/N))
- tw_im  out  TW_WIDTH  signed imaginary part, -round(1024*sin(2πe/N))
- tw_last  out  1  marks the final twiddle of the stage (j=N/2-1)
- busy  out  1  high from start acceptance until the last handshake
- done  out  1  one-cycle pulse on the cycle after the last handshake
- err  out  1  one-cycle pulse when start arrives with stage>=LOG2N

Behaviour:
- Reset (async assert, sync deassert): tw_valid=0, tw_re=0, tw_im=0, tw_last=0, busy=0, done=0, err=0; FSM=IDLE; counters=0.
- ROM C[m] = round(1024*cos(2πm/N)), for m=0..N/4, round half away from zero. Contents fixed at elaboration (e.g. C[0]=1024, C[N/4]=0).
- Exponent for butterfly j (0..N/2-1) at stage s: e = (j mod (N>>(s+1))) << s; range 0..N/2-1.
- Symmetry mapping:
  - e<N/4: re=C[e], im=-C[N/4-e].
  - e>=N/4, with m=e-N/4: re=-C[N/4-m], im=-C[m].
  - Negation is exact; no overflow, since |value|<=1024.
- FSM IDLE:
  - start with stage<LOG2N: latch s, set j=0, busy=1, go to RUN.
  - start with stage>=LOG2N: pulse err, stay in IDLE, busy stays 0.
- FSM RUN: two-stage pipeline.
  - P1 registers e and the quadrant flag.
  - P2 registers ROM read plus sign, producing tw_re/tw_im/tw_valid/tw_last.
  - First tw_valid rises 2 cycles after the start-accept edge.
  - j increments each cycle the pipeline advances.
  - After issuing j=N/2-1, stop issuing and go to DRAIN.
- FSM DRAIN: wait for the handshake with tw_last=1, then go to IDLE. busy drops and done pulses on that transition cycle.
- Backpressure:
  - Handshake = tw_valid & tw_ready.
  - If tw_valid & !tw_ready, all pipeline registers and j stall; outputs hold stable, with no drop or duplicate.
  - Sustained ready gives one twiddle per clock.
- tw_valid never deasserts without a handshake once asserted.
- start while busy is ignored (no err).
- Exactly N/2 handshakes per accepted start. tw_last is high only on the N/2-th.
- Reset mid-stage aborts immediately to the reset state; no done is produced.
- The stage input is don't-care except when start is sampled in IDLE.

Test Plan:
- N=64, s=0, tw_ready=1 -> 32 outputs, first valid 2 cycles after start. Check j=0 (1024,0), j=8 (724,-724), j=16 (0,-1024), j=24 (-724,-724), j=31 (-1019,-100); tw_last only on j=31; done 1 cycle after.
- s=1 -> e=(j mod 16)<<1: j=4 gives (724,-724), j=16 gives (1024,0), j=31 gives (-1004,-200). s=5 -> all 32 outputs (1024,0).
- Random tw_ready toggling (~50%) during s=2 -> output sequence identical to the ready=1 run, values stable while stalled, exactly 32 handshakes.
- start pulsed mid-run with a different stage -> ignored; current sequence unchanged, no err. start with stage=6 in IDLE -> err 1-cycle pulse, busy stays 0, no tw_valid.
- rst_n low at j=10 of s=0 -> all outputs 0 asynchronously, no done. New start after release -> a fresh sequence from j=0.
- Back-to-back: start asserted on the done cycle -> accepted; next sequence first valid 2 cycles later, no overlap with the prior tw_last.
